// File: rtl/cu_microop_decoder_if.sv
// Decoder bus: counter state and handshake inputs toward the decoder, control strobes and status back.
interface cu_microop_decoder_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
);
  logic [N-1:0]     state;
  logic             mem_rdy;
  logic             run;
  logic             step;
  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_inc;
  logic             ar_ld_pc;
  logic             ar_ld_dr;
  logic             pc_inc;
  logic             pc_ld;
  logic             dr_ld;
  logic             ir_ld;
  logic             ac_ld;
  logic             ac_inc;
  logic             alu_sel;
  logic             mem_rd;
  logic             halted;
  logic             err;
  logic [N-1:0]     fault_state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output state, mem_rdy, run, step,
    input  cnt_clr, cnt_load, cnt_inc, ar_ld_pc, ar_ld_dr, pc_inc, pc_ld,
           dr_ld, ir_ld, ac_ld, ac_inc, alu_sel, mem_rd, halted, err,
           fault_state, instr_cnt
  );

  modport slave (
    input  state, mem_rdy, run, step,
    output cnt_clr, cnt_load, cnt_inc, ar_ld_pc, ar_ld_dr, pc_inc, pc_ld,
           dr_ld, ir_ld, ac_ld, ac_inc, alu_sel, mem_rd, halted, err,
           fault_state, instr_cnt
  );
endinterface

// File: rtl/cu_microop_decoder.sv
// Micro-op decoder for the simple CPU control unit: state decode, memory wait/timeout, step gating, error capture.
// Optional retired-instruction counter built only when CU_INSTR_COUNT_EN is defined.
module cu_microop_decoder #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                clr,
  cu_microop_decoder_if.slave bus
);

  typedef enum logic [N-1:0] {
    FETCH1 = N'(0),
    FETCH2 = N'(1),
    FETCH3 = N'(2),
    AND1   = N'(3),
    AND2   = N'(4),
    ADD1   = N'(5),
    ADD2   = N'(6),
    JMP1   = N'(7),
    INC1   = N'(8)
  } state_e;

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic          r_err;
  logic [N-1:0]  r_fault_state;
  logic [WW-1:0] r_wait;
  logic          r_step_pend;

  state_e w_state;
  logic   w_rd_state;
  logic   w_timeout;
  logic   w_illegal;
  logic   w_go;

  assign w_state    = state_e'(bus.state);
  assign w_rd_state = (w_state == FETCH2) || (w_state == AND1) || (w_state == ADD1);
  assign w_illegal  = (bus.state > INC1);
  assign w_go       = r_step_pend | bus.step;
  // r_wait holds the count of earlier not-ready cycles, so this cycle is the TIMEOUT-th one.
  assign w_timeout  = w_rd_state && !bus.mem_rdy && !r_err && (r_wait == WW'(TIMEOUT - 1));

  always_comb begin
    bus.cnt_clr  = 1'b0;
    bus.cnt_load = 1'b0;
    bus.cnt_inc  = 1'b0;
    bus.ar_ld_pc = 1'b0;
    bus.ar_ld_dr = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_ld    = 1'b0;
    bus.dr_ld    = 1'b0;
    bus.ir_ld    = 1'b0;
    bus.ac_ld    = 1'b0;
    bus.ac_inc   = 1'b0;
    bus.alu_sel  = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.halted   = 1'b0;
    if (clr || r_err || w_illegal || w_timeout) begin
      bus.cnt_clr = 1'b1;
    end else begin
      case (w_state)
        FETCH1: begin
          if (bus.run || w_go) begin
            bus.ar_ld_pc = 1'b1;
            bus.cnt_inc  = 1'b1;
          end else begin
            bus.halted = 1'b1;
          end
        end
        FETCH2: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_rdy) begin
            bus.dr_ld   = 1'b1;
            bus.pc_inc  = 1'b1;
            bus.cnt_inc = 1'b1;
          end
        end
        FETCH3: begin
          bus.ir_ld    = 1'b1;
          bus.ar_ld_dr = 1'b1;
          bus.cnt_load = 1'b1;
        end
        AND1, ADD1: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_rdy) begin
            bus.dr_ld   = 1'b1;
            bus.cnt_inc = 1'b1;
          end
        end
        AND2: begin
          bus.ac_ld   = 1'b1;
          bus.alu_sel = 1'b1;
          bus.cnt_clr = 1'b1;
        end
        ADD2: begin
          bus.ac_ld   = 1'b1;
          bus.cnt_clr = 1'b1;
        end
        JMP1: begin
          bus.pc_ld   = 1'b1;
          bus.cnt_clr = 1'b1;
        end
        INC1: begin
          bus.ac_inc  = 1'b1;
          bus.cnt_clr = 1'b1;
        end
        default: bus.cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_err         <= 1'b0;
      r_fault_state <= '0;
      r_wait        <= '0;
      r_step_pend   <= 1'b0;
    end else begin
      if (!r_err && (w_illegal || w_timeout)) begin
        r_err         <= 1'b1;
        r_fault_state <= bus.state;
      end
      if (!w_rd_state || bus.mem_rdy || w_timeout || r_err) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + WW'(1);
      end
      if ((w_state == FETCH1) && !bus.run) begin
        if (w_go) begin
          r_step_pend <= 1'b0;
        end
      end else if (bus.step && !bus.run) begin
        r_step_pend <= 1'b1;
      end
    end
  end

  assign bus.err         = r_err & ~clr;
  assign bus.fault_state = clr ? '0 : r_fault_state;

`ifdef CU_INSTR_COUNT_EN
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  assign w_retire = !clr && !r_err && (w_state inside {AND2, ADD2, JMP1, INC1});

  always_ff @(posedge clk) begin
    if (clr) begin
      r_instr_cnt <= '0;
    end else if (w_retire) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign bus.instr_cnt = clr ? '0 : r_instr_cnt;
`else
  assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/cu_microop_decoder.md
Name: cu_microop_decoder

Overview:
- Sits directly downstream of the control-unit state counter in the simple CPU.
- Consumes the counter's state value and produces the counter's own clr/load/inc commands plus every register-transfer control strobe for the datapath.
- Adds sequential control on top of the decode:
  - memory wait-state stalling with a timeout;
  - run/single-step gating at FETCH1;
  - sticky error capture;
  - a retired-instruction counter.

Parameters:
- N, 4, width of the state input; must match the counter.
- TIMEOUT, 16, maximum consecutive not-ready cycles allowed in a memory-read state.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset; synchronous, active-high.
- state  in  N  current counter state (0 FETCH1, 1 FETCH2, 2 FETCH3, 3 AND1, 4 AND2, 5 ADD1, 6 ADD2, 7 JMP1, 8 INC1).
- mem_rdy  in  1  memory read data valid this cycle.
- run  in  1  1 = free-run, 0 = single-step mode.
- step  in  1  one-cycle pulse requesting one instruction in step mode.
- cnt_clr  out  1  counter clear (return to FETCH1).
- cnt_load  out  1  counter load from opcode.
- cnt_inc  out  1  counter increment.
- ar_ld_pc  out  1  AR <- PC.
- ar_ld_dr  out  1  AR <- DR[5:0].
- pc_inc  out  1  PC <- PC+1.
- pc_ld  out  1  PC <- DR[5:0].
- dr_ld  out  1  DR <- M.
- ir_ld  out  1  IR <- DR[7:6].
- ac_ld  out  1  AC <- ALU result.
- ac_inc  out  1  AC <- AC+1.
- alu_sel  out  1  0 = add, 1 = and.
- mem_rd  out  1  memory read request.
- halted  out  1  stalled at FETCH1 awaiting step.
- err  out  1  sticky fault flag.
- fault_state  out  N  state value captured at the first fault.
- instr_cnt  out  CNT_W  retired instruction count.

Behaviour:
- Reset (clr=1 at an edge): err=0, fault_state=0, instr_cnt=0, wait counter=0, step_pend=0. While clr is high, all outputs are combinationally 0 except cnt_clr=1.
- Decode is combinational from state and registered flags; there is zero latency to the counter.
- Nominal per-state outputs:
  - FETCH1: ar_ld_pc, cnt_inc.
  - FETCH2: mem_rd, dr_ld, pc_inc, cnt_inc.
  - FETCH3: ir_ld, ar_ld_dr, cnt_load.
  - AND1 and ADD1: mem_rd, dr_ld, cnt_inc.
  - AND2: ac_ld, alu_sel=1, cnt_clr.
  - ADD2: ac_ld, alu_sel=0, cnt_clr.
  - JMP1: pc_ld, cnt_clr.
  - INC1: ac_inc, cnt_clr.
- Memory wait, in FETCH2, AND1 and ADD1:
  - mem_rd stays asserted.
  - dr_ld, pc_inc and cnt_inc are gated by mem_rdy.
  - The wait counter increments each cycle mem_rdy=0 and resets to 0 on mem_rdy=1 or on leaving the read state.
- Timeout:
  - Triggers on the TIMEOUT-th consecutive cycle with mem_rdy=0.
  - That cycle: cnt_clr=1, all other strobes 0, fault_state<=state, err<=1.
- Illegal state (9..15):
  - Combinationally cnt_clr=1 and all other strobes 0.
  - Next edge: err<=1; fault_state<=state, but only if err was 0.
- Once err=1:
  - All strobes are 0 except cnt_clr=1, pinning the counter at FETCH1.
  - halted=0.
  - Only clr clears err.
- Run/step gating, at FETCH1 with run=0:
  - go = step_pend | step. If go=0, all strobes 0 and halted=1.
  - If go=1, nominal FETCH1 outputs and step_pend<=0.
  - A step pulse in any other state sets step_pend<=1.
  - A step pulse while run=1 is ignored.
  - Multiple pulses before FETCH1 collapse to one.
  - Run/step gating does not affect states other than FETCH1; an instruction in progress always completes.
- Retirement: instr_cnt increments by 1 on the cycle cnt_clr is asserted by AND2, ADD2, JMP1 or INC1. It does not increment for fault clears and wraps modulo 2^CNT_W.
- Reset mid-instruction: clr wins over all other conditions. Counter and block both return to FETCH1 with flags cleared; a pending step is discarded.

Optional Feature:
- Macro name: CU_INSTR_COUNT_EN.
- Defined: the instr_cnt register and its increment logic are built as above.
- Undefined: instr_cnt is driven constant 0 and no counter register is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, run=1, mem_rdy=1, opcode 01 (ADD) → states 0,1,2,5,6,0.
  - ac_ld=1 with alu_sel=0 in state 6.
  - instr_cnt=1 afterwards.
- FETCH2 with mem_rdy held 0 for 3 cycles, then 1 → mem_rd=1 for 4 cycles.
  - cnt_inc and dr_ld low for 3 cycles, high on the 4th.
  - err=0.
- AND1 with mem_rdy=0 for TIMEOUT=16 cycles → cnt_clr=1 on the 16th cycle.
  - err=1 and fault_state=3 next cycle.
  - Counter stays at 0 thereafter until clr.
- Force state=12 → cnt_clr=1 the same cycle.
  - err=1 and fault_state=12 next cycle.
  - instr_cnt unchanged.
- run=0 at FETCH1 → halted=1, all strobes 0 for 5 cycles.
  - A step pulse then yields exactly one instruction (e.g. INC: 0,1,2,8,0), after which halted=1 again.
  - A step pulse during FETCH2 lets the next FETCH1 proceed without waiting.
- clr asserted in ADD1 → next cycle all flags 0 and instr_cnt=0.
  - With CU_INSTR_COUNT_EN undefined, instr_cnt reads 0 throughout the ADD sequence.
